led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Multi-channel LED pattern generator; parametrised successor to the single-counter blinker.
- Drives NUM_CHANNELS LED/GPIO outputs, each independently selecting off, solid, blink or PWM "breathe".
- Sits in the SoC top between the clock generator output and board LED/GPIO pins.
- Blink and breathe timebases are shared by all channels.

Parameters:
- NUM_CHANNELS, 4: number of LED outputs.
- COUNTER_SIZE, 27: blink prescaler width. Blink half-period is 2^COUNTER_SIZE cycles.
- STEP_SIZE, 16: breathe step prescaler width. Brightness steps once every 2^STEP_SIZE cycles.
- PWM_BITS, 8: brightness / PWM counter width.

Ports:
- clock  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- enable  in  1  1 = run timebases. 0 = freeze all counters and force outputs to 0.
- mode  in  2*NUM_CHANNELS  per-channel mode; channel i uses bits [2i+1:2i]. 0 = off, 1 = solid, 2 = blink, 3 = breathe.
- blink  out  NUM_CHANNELS  registered LED drive.
- blinkTick  out  1  one-cycle pulse when the blink prescaler wraps.

Behaviour:
- Reset (resetN=0, asynchronous) clears all state: blink=0, blinkTick=0, blinkCnt=0, stepCnt=0, pwmCnt=0, level=0, blinkState=0, breathe FSM=RISE.
- Counters advance only while enable=1; all state holds while enable=0.
- blinkCnt (COUNTER_SIZE bits) increments and wraps.
  - Internal tick = enable && blinkCnt==all-ones.
  - blinkState toggles on tick.
  - blinkTick is the registered tick, so it follows one edge later.
- stepCnt (STEP_SIZE bits) increments and wraps. stepTick = enable && stepCnt==all-ones.
- pwmCnt (PWM_BITS bits) increments every enabled cycle and wraps.
- Breathe FSM, evaluated only on stepTick:
  - RISE: if level==max, go to FALL and set level=max-1; else level+1.
  - FALL: if level==0, go to RISE and set level=1; else level-1.
  - Level sequence: 0,1,…,max,max-1,…,0,1,… with no repeated endpoints.
- PWM raw = (pwmCnt < level).
  - level 0 → always 0.
  - level max → high for (2^PWM_BITS)-1 of every 2^PWM_BITS cycles.
- Output register, updated every edge:
  - blink[i] = 0 if enable=0.
  - Otherwise by mode: 0 → 0; 1 → 1; 2 → blinkState; 3 → PWM raw.
- Latency:
  - Mode or enable change affects blink one edge later.
  - blinkState change appears on blink one edge after it toggles.
- Shared timebase: channels in the same mode are phase-identical. Switching mode never resets the timebases.
- enable 1→0 mid-breathe: level, FSM state and all counters freeze. Resuming continues from the frozen values.
- Reset asserted mid-operation: immediate clear, no wait for a clock edge. Release is synchronous to the next edge; the first count happens on that edge.
- Widths: all counters wrap modulo 2^width. No saturation other than the FSM endpoints.

Optional Feature:
- Macro LED_PATTERN_GAMMA_EN.
- Defined: breathe compares pwmCnt against gamma = (level*level) >> PWM_BITS, a 2*PWM_BITS-bit product truncated to PWM_BITS, giving perceptually linear fade.
  - level max → gamma = max-1 (e.g. 7*7=49, 49>>3 = 6).
  - level 0 → 0.
  - Adds no latency; the output register is unchanged.
- Undefined: linear compare against level; no multiplier is instantiated.

Test Plan (NUM_CHANNELS=4, COUNTER_SIZE=4, STEP_SIZE=2, PWM_BITS=3, enable=1):
- Reset and blink: assert resetN=0, then release with mode=all 2.
  - blink=4'b0000 and blinkTick=0 during reset.
  - blink stays 0 for edges 1–16 after release and goes 4'hF at edge 17.
  - Period is 32 cycles.
  - blinkTick pulses at edges 17, 33, …
- Mode mix: mode={3,2,1,0} (ch3..ch0).
  - ch0 is always 0; ch1 is always 1; ch2 toggles every 16 cycles.
  - Write ch1 to mode 0: ch1 drops exactly one edge later.
- Breathe: mode=all 3.
  - level steps every 4 cycles through 0,1,…,7,6,…,0,1.
  - In each 8-cycle PWM window, high count equals level.
  - Max level gives 7 highs out of 8.
- Enable freeze: drop enable for 20 cycles mid-breathe at level 5.
  - blink=0 the next edge.
  - On re-enable, level resumes at 5 and blinkCnt continues from its frozen value.
- Async reset mid-operation: pulse resetN low between clock edges while blink=4'hF.
  - Outputs clear immediately, without a clock edge.
  - Sequence restarts exactly as in the first scenario.
- Gamma (LED_PATTERN_GAMMA_EN defined): level 7 → 6 highs per 8 cycles; level 3 → 1 high; level 2 → 0 highs.

Source files
------------

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: off / solid / blink / PWM breathe.
// Define LED_PATTERN_GAMMA_EN for a squared (perceptual) breathe curve.
module led_pattern_gen #(
  parameter int NUM_CHANNELS = 4,
  parameter int COUNTER_SIZE = 27,
  parameter int STEP_SIZE    = 16,
  parameter int PWM_BITS     = 8
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      enable,
  input  logic [2*NUM_CHANNELS-1:0] mode,
  output logic [NUM_CHANNELS-1:0]   blink,
  output logic                      blinkTick
);

  typedef enum logic {
    RISE,
    FALL
  } breathe_e;

  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

  logic [COUNTER_SIZE-1:0] blink_cnt_q, blink_cnt_d;
  logic [STEP_SIZE-1:0]    step_cnt_q, step_cnt_d;
  logic [PWM_BITS-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0]     level_q, level_d;
  breathe_e                state_q, state_d;
  logic                    blink_state_q, blink_state_d;
  logic                    tick_q, tick_d;
  logic                    blink_tick_q, blink_tick_d;
  logic [NUM_CHANNELS-1:0] blink_q, blink_d;

  logic                    tick;
  logic                    step_tick;
  logic [PWM_BITS-1:0]     duty;
  logic                    pwm_raw;

`ifdef LED_PATTERN_GAMMA_EN
  logic [2*PWM_BITS-1:0]   level_sq;
  always_comb begin
    level_sq = {{PWM_BITS{1'b0}}, level_q}
             * {{PWM_BITS{1'b0}}, level_q};
    duty     = level_sq[2*PWM_BITS-1:PWM_BITS];
  end
`else
  assign duty = level_q;
`endif

  assign tick      = enable && (blink_cnt_q == '1);
  assign step_tick = enable && (step_cnt_q == '1);
  assign pwm_raw   = (pwm_cnt_q < duty);

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    step_cnt_d    = step_cnt_q;
    pwm_cnt_d     = pwm_cnt_q;
    level_d       = level_q;
    state_d       = state_q;
    blink_state_d = blink_state_q ^ tick;
    tick_d        = tick;
    // Delayed once more so the pulse lines up with the blink edge.
    blink_tick_d  = tick_q;
    blink_d       = '0;

    if (enable) begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      step_cnt_d  = step_cnt_q + 1'b1;
      pwm_cnt_d   = pwm_cnt_q + 1'b1;
    end

    if (step_tick) begin
      unique case (state_q)
        RISE: begin
          if (level_q == LVL_MAX) begin
            state_d = FALL;
            level_d = LVL_MAX - 1'b1;
          end else begin
            level_d = level_q + 1'b1;
          end
        end
        FALL: begin
          if (level_q == '0) begin
            state_d = RISE;
            level_d = {{(PWM_BITS-1){1'b0}}, 1'b1};
          end else begin
            level_d = level_q - 1'b1;
          end
        end
      endcase
    end

    if (enable) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        unique case (mode[2*i +: 2])
          2'd0: blink_d[i] = 1'b0;
          2'd1: blink_d[i] = 1'b1;
          2'd2: blink_d[i] = blink_state_q;
          2'd3: blink_d[i] = pwm_raw;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      blink_cnt_q   <= '0;
      step_cnt_q    <= '0;
      pwm_cnt_q     <= '0;
      level_q       <= '0;
      state_q       <= RISE;
      blink_state_q <= 1'b0;
      tick_q        <= 1'b0;
      blink_tick_q  <= 1'b0;
      blink_q       <= '0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      step_cnt_q    <= step_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      level_q       <= level_d;
      state_q       <= state_d;
      blink_state_q <= blink_state_d;
      tick_q        <= tick_d;
      blink_tick_q  <= blink_tick_d;
      blink_q       <= blink_d;
    end
  end

  assign blink     = blink_q;
  assign blinkTick = blink_tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen.
// Small parameters: 4 ch, 16-cycle blink half-period, 4-cycle step, 3-bit PWM.
module tb_led_pattern_gen;

  logic       clock = 1'b0;
  logic       resetN;
  logic       enable;
  logic [7:0] mode;
  logic [3:0] blink;
  logic       blinkTick;

  int checks = 0;
  int errors = 0;

  int lvl_tab [16] = '{0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1};
`ifdef LED_PATTERN_GAMMA_EN
  int hi_tab  [16] = '{0,0,0,0,2,0,4,2,4,0,2,0,0,0,0,0};
`else
  int hi_tab  [16] = '{0,0,2,0,4,1,4,3,4,1,4,0,2,0,0,0};
`endif

  always #5 clock = ~clock;

  led_pattern_gen #(
    .NUM_CHANNELS(4),
    .COUNTER_SIZE(4),
    .STEP_SIZE(2),
    .PWM_BITS(3)
  ) dut (
    .clock(clock),
    .resetN(resetN),
    .enable(enable),
    .mode(mode),
    .blink(blink),
    .blinkTick(blinkTick)
  );

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic apply_reset(input logic [7:0] m);
    @(negedge clock);
    resetN = 1'b0;
    enable = 1'b1;
    mode   = m;
    repeat (3) @(negedge clock);
    resetN = 1'b1;
  endtask

  task automatic test_reset_blink();
    logic [3:0] exp_b;
    logic       exp_t;
    resetN = 1'b0;
    enable = 1'b1;
    mode   = 8'hAA;
    repeat (3) @(negedge clock);
    checks++;
    if (blink !== 4'h0 || blinkTick !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: blink=%h tick=%b want 0 0",
               blink, blinkTick);
    end
    checks++;
    if (dut.level_q !== 3'd0 || dut.blink_cnt_q !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: level=%0d cnt=%0d want 0 0",
               dut.level_q, dut.blink_cnt_q);
    end
    resetN = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      exp_b = (k >= 17 && k <= 32) ? 4'hF : 4'h0;
      exp_t = (k == 17 || k == 33);
      checks++;
      if (blink !== exp_b || blinkTick !== exp_t) begin
        errors++;
        $display("FAIL blink_edge%0d: blink=%h tick=%b want %h %b",
                 k, blink, blinkTick, exp_b, exp_t);
      end
    end
  endtask

  task automatic test_mode_mix();
    logic exp2;
    apply_reset(8'hE4);
    for (int k = 1; k <= 40; k++) begin
      step();
      exp2 = (k >= 17 && k <= 32);
      checks++;
      if (blink[0] !== 1'b0 || blink[1] !== 1'b1
          || blink[2] !== exp2) begin
        errors++;
        $display("FAIL mix_edge%0d: blink=%b want ch0=0 ch1=1 ch2=%b",
                 k, blink, exp2);
      end
    end
    mode = 8'hE0;
    #1;
    checks++;
    if (blink[1] !== 1'b1) begin
      errors++;
      $display("FAIL mix_no_edge: ch1=%b want 1", blink[1]);
    end
    step();
    checks++;
    if (blink[1] !== 1'b0) begin
      errors++;
      $display("FAIL mix_ch1_off: ch1=%b want 0", blink[1]);
    end
  endtask

  task automatic test_breathe();
    int hi;
    apply_reset(8'hFF);
    for (int n = 0; n < 16; n++) begin
      hi = 0;
      for (int j = 1; j <= 4; j++) begin
        step();
        if (j == 1) begin
          checks++;
          if (int'(dut.level_q) != lvl_tab[n]) begin
            errors++;
            $display("FAIL level_step%0d: level=%0d want %0d",
                     n, dut.level_q, lvl_tab[n]);
          end
        end
        checks++;
        if (blink !== 4'h0 && blink !== 4'hF) begin
          errors++;
          $display("FAIL breathe_phase: blink=%h want 0 or F", blink);
        end
        if (blink[0] === 1'b1) hi++;
      end
      checks++;
      if (hi != hi_tab[n]) begin
        errors++;
        $display("FAIL highs_step%0d: highs=%0d want %0d",
                 n, hi, hi_tab[n]);
      end
    end
  endtask

  task automatic test_enable_freeze();
    apply_reset(8'hFF);
    repeat (22) step();
    checks++;
    if (dut.level_q !== 3'd5 || dut.blink_cnt_q !== 4'd6) begin
      errors++;
      $display("FAIL pre_freeze: level=%0d cnt=%0d want 5 6",
               dut.level_q, dut.blink_cnt_q);
    end
    enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (blink !== 4'h0 || blinkTick !== 1'b0
          || dut.level_q !== 3'd5 || dut.blink_cnt_q !== 4'd6) begin
        errors++;
        $display("FAIL freeze%0d: blink=%h lvl=%0d cnt=%0d want 0 5 6",
                 k, blink, dut.level_q, dut.blink_cnt_q);
      end
    end
    enable = 1'b1;
    step();
    checks++;
    if (dut.level_q !== 3'd5 || dut.blink_cnt_q !== 4'd7) begin
      errors++;
      $display("FAIL resume1: level=%0d cnt=%0d want 5 7",
               dut.level_q, dut.blink_cnt_q);
    end
    step();
    checks++;
    if (dut.level_q !== 3'd6 || dut.blink_cnt_q !== 4'd8) begin
      errors++;
      $display("FAIL resume2: level=%0d cnt=%0d want 6 8",
               dut.level_q, dut.blink_cnt_q);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_b;
    logic       exp_t;
    apply_reset(8'hAA);
    repeat (20) step();
    checks++;
    if (blink !== 4'hF) begin
      errors++;
      $display("FAIL pre_async: blink=%h want f", blink);
    end
    #2;
    resetN = 1'b0;
    #1;
    checks++;
    if (blink !== 4'h0 || blinkTick !== 1'b0
        || dut.blink_cnt_q !== 4'd0) begin
      errors++;
      $display("FAIL async_clear: blink=%h tick=%b cnt=%0d want 0 0 0",
               blink, blinkTick, dut.blink_cnt_q);
    end
    @(negedge clock);
    resetN = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      step();
      exp_b = (k >= 17 && k <= 32) ? 4'hF : 4'h0;
      exp_t = (k == 17 || k == 33);
      checks++;
      if (blink !== exp_b || blinkTick !== exp_t) begin
        errors++;
        $display("FAIL restart_edge%0d: blink=%h tick=%b want %h %b",
                 k, blink, blinkTick, exp_b, exp_t);
      end
    end
  endtask

  initial begin
    resetN = 1'b0;
    enable = 1'b1;
    mode   = 8'h00;
    test_reset_blink();
    test_mode_mix();
    test_breathe();
    test_enable_freeze();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
